// File: rtl/keccak_lane_feeder.sv
// Byte-to-lane packer in front of the keccak core: collects message bytes
// into 64-bit little-endian lanes and hands them over with a valid/ready pair.
module keccak_lane_feeder #(
    parameter int BW_CTRL = 2,
    parameter int BW_ILEN = 11,
    parameter int BW_OLEN = 10
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [BW_CTRL-1:0] i_mode,
    input  logic [BW_ILEN-1:0] i_ibyte_len,
    input  logic [BW_OLEN-1:0] i_obyte_len,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    output logic [63:0]        o_bytes,
    output logic               o_bytes_valid,
    input  logic               i_bytes_ready,
    output logic [BW_CTRL-1:0] o_mode,
    output logic [BW_ILEN-1:0] o_ibyte_len,
    output logic [BW_OLEN-1:0] o_obyte_len,
    output logic [3:0]         o_lane_nbytes,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SEND,
        DONE
    } state_t;

    localparam logic [BW_ILEN-1:0] LEN_ONE = BW_ILEN'(1);

    state_t             state_q;
    state_t             state_d;
    logic [63:0]        lane_q;
    logic [3:0]         nbytes_q;
    logic [BW_ILEN-1:0] remaining_q;
    logic [BW_CTRL-1:0] mode_q;
    logic [BW_ILEN-1:0] ilen_q;
    logic [BW_OLEN-1:0] olen_q;

    logic start_acc;
    logic byte_acc;
    logic lane_end;
    logic lane_acc;
    logic last_lane;

    assign start_acc = (state_q == IDLE) & i_start;
    assign byte_acc  = (state_q == COLLECT) & i_byte_valid;
    assign last_lane = (remaining_q == '0);
    assign lane_acc  = (state_q == SEND) & i_bytes_ready;
    // Lane closes on its 8th byte or on the final message byte.
    assign lane_end  = byte_acc
                     & ((nbytes_q == 4'd7) | (remaining_q == LEN_ONE));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = (i_ibyte_len == '0) ? SEND : COLLECT;
                end
            end
            COLLECT: begin
                if (lane_end) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_bytes_ready) begin
                    state_d = last_lane ? DONE : COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_byte_ready  = 1'b0;
        o_bytes_valid = 1'b0;
        o_last        = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            COLLECT: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            SEND: begin
                o_bytes_valid = 1'b1;
                o_last        = last_lane;
                o_busy        = 1'b1;
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lane_q      <= '0;
            nbytes_q    <= '0;
            remaining_q <= '0;
            mode_q      <= '0;
            ilen_q      <= '0;
            olen_q      <= '0;
        end else begin
            if (start_acc) begin
                mode_q      <= i_mode;
                ilen_q      <= i_ibyte_len;
                olen_q      <= i_obyte_len;
                lane_q      <= '0;
                nbytes_q    <= '0;
                remaining_q <= i_ibyte_len;
            end
            if (byte_acc) begin
                lane_q[{nbytes_q[2:0], 3'b000} +: 8] <= i_byte;
                nbytes_q    <= nbytes_q + 4'd1;
                remaining_q <= remaining_q - LEN_ONE;
            end
            // Non-final lanes restart empty so unfilled bytes stay zero.
            if (lane_acc && !last_lane) begin
                lane_q   <= '0;
                nbytes_q <= '0;
            end
        end
    end

    assign o_bytes       = lane_q;
    assign o_lane_nbytes = nbytes_q;
    assign o_mode        = mode_q;
    assign o_ibyte_len   = ilen_q;
    assign o_obyte_len   = olen_q;

endmodule

// File: tb/tb_keccak_lane_feeder.sv
// Randomized bench for keccak_lane_feeder: a lane-list reference model
// built from the message bytes is compared against every presented lane.
module tb_keccak_lane_feeder;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = '0;
    logic [10:0] i_ibyte_len = '0;
    logic [9:0]  i_obyte_len = '0;
    logic [7:0]  i_byte = '0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic [63:0] o_bytes;
    logic        o_bytes_valid;
    logic        i_bytes_ready = 1'b0;
    logic [1:0]  o_mode;
    logic [10:0] o_ibyte_len;
    logic [9:0]  o_obyte_len;
    logic [3:0]  o_lane_nbytes;
    logic        o_last;
    logic        o_busy;
    logic        o_done;

    keccak_lane_feeder dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_mode        (i_mode),
        .i_ibyte_len   (i_ibyte_len),
        .i_obyte_len   (i_obyte_len),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .o_bytes       (o_bytes),
        .o_bytes_valid (o_bytes_valid),
        .i_bytes_ready (i_bytes_ready),
        .o_mode        (o_mode),
        .o_ibyte_len   (o_ibyte_len),
        .o_obyte_len   (o_obyte_len),
        .o_lane_nbytes (o_lane_nbytes),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  msg [0:1183];
    logic [63:0] exp_lane [0:147];
    int          exp_nb [0:147];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_zero(input string tag);
        chk({tag, "_bytes"}, o_bytes, 64'd0);
        chk({tag, "_ctrl"},
            {32'd0, o_byte_ready, o_bytes_valid, o_mode, o_ibyte_len,
             o_obyte_len, o_lane_nbytes, o_last, o_busy, o_done},
            64'd0);
    endtask

    // Drives one message and checks every lane presented for it.
    task automatic run_msg(input int len, input logic [1:0] mode,
                           input logic [9:0] olen, input int vpct,
                           input int rpct, input int stall0,
                           input int restart_at, input int abort_bidx,
                           output int done_iter);
        int nl;
        int bidx;
        int lidx;
        int last_acc;
        int stalled;
        int max_iter;
        bit new_lane;
        bit finished;
        bit restarted;

        nl = (len == 0) ? 1 : (len + 7) / 8;
        for (int i = 0; i < nl; i++) begin
            exp_lane[i] = '0;
            exp_nb[i] = (len - 8 * i > 8) ? 8 : len - 8 * i;
            for (int k = 0; k < exp_nb[i]; k++)
                exp_lane[i][8*k +: 8] = msg[8*i + k];
        end
        bidx = 0;
        lidx = 0;
        last_acc = -100;
        stalled = 0;
        new_lane = 1'b1;
        finished = 1'b0;
        restarted = 1'b0;
        done_iter = -1;
        max_iter = 20 * len + 100;

        @(negedge i_clk);
        chk("idle_busy", {63'd0, o_busy}, 64'd0);
        chk("idle_ready", {63'd0, o_byte_ready}, 64'd0);
        i_start = 1'b1;
        i_mode = mode;
        i_ibyte_len = 11'(len);
        i_obyte_len = olen;
        i_byte_valid = ($urandom_range(99) < 50);
        i_byte = $urandom;
        i_bytes_ready = (stall0 > 0) ? 1'b0 : ($urandom_range(99) < rpct);

        for (int iter = 1; iter <= max_iter; iter++) begin
            @(negedge i_clk);
            chk("latched_mode", {62'd0, o_mode}, {62'd0, mode});
            chk("latched_ilen", {53'd0, o_ibyte_len}, 64'(len));
            chk("latched_olen", {54'd0, o_obyte_len}, {54'd0, olen});
            if (abort_bidx >= 0 && bidx == abort_bidx) begin
                i_rstn = 1'b0;
                #1;
                chk_reset_zero("async_reset");
                done_iter = iter;
                return;
            end
            if (o_done) begin
                done_iter = iter;
                chk("lane_count", 64'(lidx), 64'(nl));
                chk("byte_count", 64'(bidx), 64'(len));
                chk("done_busy", {63'd0, o_busy}, 64'd0);
                finished = 1'b1;
                break;
            end
            if (o_bytes_valid) begin
                chk("lane_in_range", {63'd0, lidx < nl}, 64'd1);
                if (lidx < nl) begin
                    if (new_lane && exp_nb[lidx] > 0)
                        chk("valid_latency", 64'(iter), 64'(last_acc + 1));
                    chk("lane_data", o_bytes, exp_lane[lidx]);
                    chk("lane_nbytes", {60'd0, o_lane_nbytes},
                        64'(exp_nb[lidx]));
                    chk("lane_last", {63'd0, o_last},
                        {63'd0, lidx == nl - 1});
                end
                chk("ready_in_send", {63'd0, o_byte_ready}, 64'd0);
                new_lane = 1'b0;
            end

            i_start = 1'b0;
            i_mode = mode;
            i_ibyte_len = 11'(len);
            i_obyte_len = olen;
            if (restart_at >= 0 && bidx == restart_at && !restarted) begin
                i_start = 1'b1;
                i_mode = 2'd3;
                i_ibyte_len = 11'd20;
                i_obyte_len = ~olen;
                restarted = 1'b1;
            end
            i_byte_valid = ($urandom_range(99) < vpct);
            i_byte = (bidx < len) ? msg[bidx] : 8'($urandom);
            if (lidx == 0 && stalled < stall0) begin
                i_bytes_ready = 1'b0;
                if (o_bytes_valid) stalled++;
            end else begin
                i_bytes_ready = ($urandom_range(99) < rpct);
            end

            if (o_byte_ready && i_byte_valid) begin
                bidx++;
                last_acc = iter;
            end
            if (o_bytes_valid && i_bytes_ready) begin
                lidx++;
                new_lane = 1'b1;
            end
        end

        if (!finished) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            i_start = 1'b0;
            @(negedge i_clk);
            chk("done_one_cycle", {63'd0, o_done}, 64'd0);
            chk("post_busy", {63'd0, o_busy}, 64'd0);
            chk("post_mode", {62'd0, o_mode}, {62'd0, mode});
            chk("post_ilen", {53'd0, o_ibyte_len}, 64'(len));
        end
        i_byte_valid = 1'b0;
        i_bytes_ready = 1'b0;
    endtask

    int done_iter;
    int lens [6] = '{1, 7, 9, 16, 63, 250};

    initial begin
        #1;
        chk_reset_zero("reset");
        repeat (2) @(negedge i_clk);
        chk_reset_zero("reset_held");
        i_rstn = 1'b1;

        run_msg(0, 2'd2, 10'd32, 100, 100, 0, -1, -1, done_iter);
        chk("zero_len_done_cycle", 64'(done_iter), 64'd2);

        for (int i = 0; i < 8; i++) msg[i] = 8'(i + 1);
        run_msg(8, 2'd0, 10'd32, 100, 100, 0, -1, -1, done_iter);

        for (int i = 0; i < 13; i++) msg[i] = 8'(i);
        run_msg(13, 2'd1, 10'd64, 100, 100, 5, -1, -1, done_iter);
        run_msg(13, 2'd1, 10'd64, 80, 60, 5, 10, -1, done_iter);

        foreach (lens[j]) begin
            for (int i = 0; i < lens[j]; i++) msg[i] = 8'($urandom);
            run_msg(lens[j], 2'($urandom), 10'($urandom), 70, 60,
                    0, -1, -1, done_iter);
        end

        for (int i = 0; i < 1184; i++) msg[i] = 8'($urandom);
        run_msg(1184, 2'd3, 10'd784, 100, 100, 0, -1, 43, done_iter);
        @(negedge i_clk);
        i_rstn = 1'b1;
        i_byte_valid = 1'b1;
        i_bytes_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            chk("post_abort_valid", {63'd0, o_bytes_valid}, 64'd0);
            chk("post_abort_busy", {63'd0, o_busy}, 64'd0);
        end
        i_byte_valid = 1'b0;
        i_bytes_ready = 1'b0;

        for (int i = 0; i < 1184; i++) msg[i] = 8'($urandom);
        run_msg(1184, 2'd2, 10'd784, 75, 70, 0, -1, -1, done_iter);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_lane_feeder.md
Name: keccak_lane_feeder

Overview:
Transmit-side front end for the keccak core. It accepts a message one byte at a time over a valid/ready handshake and packs the bytes into 64-bit little-endian lanes. Each lane is presented to the core on the o_bytes/o_bytes_valid side of the keccak input interface, together with the latched mode and byte-length controls. The block sits between the Kyber datapath (byte producers) and keccak; the final partial lane is zero-filled and flagged.

Parameters:
BW_CTRL, 2, width of mode field (SHA3-256/SHA3-512/SHAKE128/SHAKE256 select)
BW_ILEN, 11, width of input byte length (max 1184 bytes)
BW_OLEN, 10, width of output byte length (max 784 bytes)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_start  in  1  begin a message; samples i_mode/i_ibyte_len/i_obyte_len
i_mode  in  BW_CTRL  hash mode for this message
i_ibyte_len  in  BW_ILEN  message length in bytes (0..1184)
i_obyte_len  in  BW_OLEN  requested output length in bytes
i_byte  in  8  message byte
i_byte_valid  in  1  i_byte valid
o_byte_ready  out  1  feeder accepts i_byte this cycle
o_bytes  out  64  packed lane to keccak
o_bytes_valid  out  1  lane valid, held until accepted
i_bytes_ready  in  1  keccak accepts lane
o_mode  out  BW_CTRL  latched mode
o_ibyte_len  out  BW_ILEN  latched input length
o_obyte_len  out  BW_OLEN  latched output length
o_lane_nbytes  out  4  valid bytes in current lane (0..8)
o_last  out  1  current lane is final lane of message
o_busy  out  1  message in progress
o_done  out  1  one-cycle pulse after final lane accepted

Behaviour:
- Reset (async, i_rstn=0): all outputs 0; FSM to IDLE; counters, lane register and latched controls cleared. Reset mid-message aborts it; no partial lane is emitted after release.
- FSM states: IDLE, COLLECT, SEND, DONE.
- IDLE: o_busy=0, o_byte_ready=0. i_start=1 latches mode/lengths, clears lane register to zero and sets remaining=i_ibyte_len. Next state is COLLECT, or SEND directly if i_ibyte_len=0.
- COLLECT: o_busy=1, o_byte_ready=1. A byte is accepted when i_byte_valid & o_byte_ready. The k-th byte of the lane (k=0..7) goes to o_bytes[8k+7:8k]; remaining decrements. The block goes to SEND on the cycle after the 8th byte of the lane or the final message byte is accepted. Latency: lane accepted at edge t gives o_bytes_valid=1 from t+1.
- SEND: o_byte_ready=0; o_bytes_valid=1; o_bytes, o_lane_nbytes and o_last are stable until i_bytes_ready=1. Unfilled bytes are 0.
  - o_lane_nbytes = bytes packed, which is 8 except on a partial final lane.
  - o_last=1 when remaining=0.
  - On accept: if o_last, go to DONE; else clear the lane and return to COLLECT.
  - A lane can be accepted on the first cycle it is valid.
- Zero-length message: exactly one lane with o_bytes=0, o_lane_nbytes=0, o_last=1.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. The latched o_mode/o_ibyte_len/o_obyte_len keep their values until the next i_start.
- i_start while busy (COLLECT/SEND/DONE) is ignored; the latched controls do not change.
- Lane count per message = ceil(len/8), or 1 if len=0; max 148 for len 1184. Byte counter width is BW_ILEN; no wrap within legal lengths. i_ibyte_len>1184 is illegal; behaviour is not checked.
- i_byte_valid outside COLLECT is ignored and consumes no data.

Test Plan:
- len=0, mode=2, i_bytes_ready=1 -> one lane o_bytes=0, nbytes=0, o_last=1; o_done pulses 2 cycles after start.
- len=8, bytes 01..08 -> single lane o_bytes=64'h0807060504030201, nbytes=8, o_last=1; valid rises the cycle after byte 08 is accepted.
- len=13, bytes 00..0C -> lane0 64'h0706050403020100 with nbytes=8 and o_last=0; lane1 64'h0000000C0B0A0908 with nbytes=5 and o_last=1.
- Backpressure: i_bytes_ready low 5 cycles during lane0 of the len=13 message -> o_bytes_valid held and data stable; o_byte_ready=0 throughout; no byte lost.
- Second i_start with mode=3, len=20 mid-message -> ignored; o_mode/o_ibyte_len unchanged; the original message completes.
- i_rstn low while 3 bytes are into lane 5 of a len=1184 message -> all outputs 0 immediately. A fresh len=1184 run emits 148 lanes, the last with nbytes=8 and o_last=1.
